cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit,
// round-robin grant, registered broadcast on the falling clock edge.
module cdb_arbiter #(
    parameter int NREQ  = 4,
    parameter int ROB   = 2,
    parameter int WIDTH = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*(ROB+1)-1:0]     req_robEntry,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_result,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        flush,
    output logic                        validBroadcast,
    output logic [ROB:0]                robEntry,
    output logic [WIDTH:0]              result,
    output logic [1:0]                  grant_src
);

    logic [NREQ-1:0] hold_v;
    logic [ROB:0]    hold_rob [NREQ];
    logic [WIDTH:0]  hold_res [NREQ];
    logic [1:0]      rr_ptr;

    logic [NREQ-1:0] grant;
    logic [1:0]      gidx;
    logic [1:0]      idx;
    logic            found;

    // Round-robin search over occupied slots starting at rr_ptr
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + k[1:0];
            if (!found && hold_v[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    // A slot accepts when empty or when it is being drained this cycle
    always_comb begin
        req_ready = {NREQ{reset & ~flush}} & (~hold_v | grant);
    end

    // Slot bookkeeping and registered broadcast, aligned with the ROB edge
    always_ff @(negedge clk) begin
        if (!reset) begin
            hold_v         <= '0;
            validBroadcast <= 1'b0;
            robEntry       <= '0;
            result         <= '0;
            grant_src      <= '0;
            rr_ptr         <= '0;
        end else if (flush) begin
            hold_v         <= '0;
            validBroadcast <= 1'b0;
        end else begin
            if (found) begin
                validBroadcast <= 1'b1;
                robEntry       <= hold_rob[gidx];
                result         <= hold_res[gidx];
                grant_src      <= gidx;
                rr_ptr         <= gidx + 2'd1;
                hold_v[gidx]   <= 1'b0;
            end else begin
                validBroadcast <= 1'b0;
            end
            // A reload of the granted slot overrides its clear above
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold_v[i]   <= 1'b1;
                    hold_rob[i] <= req_robEntry[i*(ROB+1) +: ROB+1];
                    hold_res[i] <= req_result[i*(WIDTH+1) +: WIDTH+1];
                end
            end
        end
    end

endmodule
